// File: rtl/lif_param_loader_multi.sv
// rtl/lif_param_loader_multi.sv - serial, checksummed parameter loader for an array of dual-leak LIF channels
module lif_param_loader_multi #(
    parameter int N_CH     = 4,
    parameter int W_WEIGHT = 3,
    parameter int W_RATE   = 8,
    parameter int W_THR    = 8,
    parameter int W_CYC    = 4,
    parameter int DEF_WA   = 2,
    parameter int DEF_LR1  = 2,
    parameter int DEF_LR2  = 1,
    parameter int DEF_THR  = 30,
    parameter int DEF_LC1  = 2,
    parameter int DEF_LC2  = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       serial_data_in,
    input  logic                       load_enable,
    output logic [N_CH*W_WEIGHT-1:0]   weight_a,
    output logic [N_CH*W_RATE-1:0]     leak_rate_1,
    output logic [N_CH*W_RATE-1:0]     leak_rate_2,
    output logic [N_CH*W_THR-1:0]      threshold,
    output logic [N_CH*W_CYC-1:0]      leak_cycles_1,
    output logic [N_CH*W_CYC-1:0]      leak_cycles_2,
    output logic                       params_ready,
    output logic                       csum_err,
    output logic                       addr_err,
    output logic [7:0]                 frame_count
);
    typedef enum logic [1:0] {IDLE = 2'd0, RX = 2'd1, CHECK = 2'd2, DONE = 2'd3} state_t;

    state_t              state, state_nxt;
    logic [2:0]          bit_cnt, byte_cnt;
    logic [6:0]          shift_q;
    logic [7:0]          csum_q, sh_addr, byte_now;
    logic [W_WEIGHT-1:0] sh_wa;
    logic [W_RATE-1:0]   sh_lr1, sh_lr2;
    logic [W_THR-1:0]    sh_thr;
    logic [W_CYC-1:0]    sh_lc1, sh_lc2;
    logic                last_bit, csum_bad, idx_bad;
    logic                frame_start, shift_en, abort, check, commit;

    assign byte_now = {shift_q, serial_data_in};
    assign last_bit = (bit_cnt == 3'd7) && (byte_cnt == 3'd7);
    // csum_q already has B7 folded in when CHECK is reached, so a good frame leaves zero
    assign csum_bad = (csum_q != 8'd0);
    assign idx_bad  = ~sh_addr[7] && ({1'b0, sh_addr[6:0]} >= 8'(N_CH));
    assign commit   = check & ~csum_bad & ~idx_bad;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else if (enable)
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (load_enable) state_nxt = RX;
            RX:      if (!load_enable) state_nxt = IDLE;
                     else if (last_bit) state_nxt = CHECK;
            CHECK:   state_nxt = DONE;
            DONE:    if (!load_enable) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        frame_start = 1'b0;
        shift_en    = 1'b0;
        abort       = 1'b0;
        check       = 1'b0;
        if (enable) begin
            case (state)
                IDLE:    frame_start = load_enable;
                RX:      begin
                             shift_en = load_enable;
                             abort    = ~load_enable;
                         end
                CHECK:   check = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt      <= 3'd0;
            byte_cnt     <= 3'd0;
            shift_q      <= 7'd0;
            csum_q       <= 8'd0;
            sh_addr      <= 8'd0;
            sh_wa        <= '0;
            sh_lr1       <= '0;
            sh_lr2       <= '0;
            sh_thr       <= '0;
            sh_lc1       <= '0;
            sh_lc2       <= '0;
            params_ready <= 1'b1;
            csum_err     <= 1'b0;
            addr_err     <= 1'b0;
            frame_count  <= 8'd0;
        end else begin
            if (frame_start) begin
                bit_cnt      <= 3'd0;
                byte_cnt     <= 3'd0;
                csum_q       <= 8'd0;
                csum_err     <= 1'b0;
                addr_err     <= 1'b0;
                params_ready <= 1'b0;
            end
            if (shift_en) begin
                shift_q <= byte_now[6:0];
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    byte_cnt <= byte_cnt + 3'd1;
                    csum_q   <= csum_q ^ byte_now;
                    case (byte_cnt)
                        3'd0:    sh_addr <= byte_now;
                        3'd1:    sh_wa   <= byte_now[W_WEIGHT-1:0];
                        3'd2:    sh_lr1  <= byte_now[W_RATE-1:0];
                        3'd3:    sh_lr2  <= byte_now[W_RATE-1:0];
                        3'd4:    sh_thr  <= byte_now[W_THR-1:0];
                        3'd5:    sh_lc1  <= byte_now[W_CYC-1:0];
                        3'd6:    sh_lc2  <= byte_now[W_CYC-1:0];
                        default: ;
                    endcase
                end
            end
            if (abort)
                params_ready <= 1'b1;
            if (check) begin
                params_ready <= 1'b1;
                if (csum_bad)
                    csum_err <= 1'b1;
                else if (idx_bad)
                    addr_err <= 1'b1;
                else
                    frame_count <= frame_count + 8'd1;
            end
        end
    end

    // All six fields of a channel move together on the commit edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < N_CH; k++) begin
                weight_a[k*W_WEIGHT +: W_WEIGHT]  <= W_WEIGHT'(DEF_WA);
                leak_rate_1[k*W_RATE +: W_RATE]   <= W_RATE'(DEF_LR1);
                leak_rate_2[k*W_RATE +: W_RATE]   <= W_RATE'(DEF_LR2);
                threshold[k*W_THR +: W_THR]       <= W_THR'(DEF_THR);
                leak_cycles_1[k*W_CYC +: W_CYC]   <= W_CYC'(DEF_LC1);
                leak_cycles_2[k*W_CYC +: W_CYC]   <= W_CYC'(DEF_LC2);
            end
        end else if (commit) begin
            for (int k = 0; k < N_CH; k++) begin
                if (sh_addr[7] || (sh_addr[6:0] == 7'(k))) begin
                    weight_a[k*W_WEIGHT +: W_WEIGHT]  <= sh_wa;
                    leak_rate_1[k*W_RATE +: W_RATE]   <= sh_lr1;
                    leak_rate_2[k*W_RATE +: W_RATE]   <= sh_lr2;
                    threshold[k*W_THR +: W_THR]       <= sh_thr;
                    leak_cycles_1[k*W_CYC +: W_CYC]   <= sh_lc1;
                    leak_cycles_2[k*W_CYC +: W_CYC]   <= sh_lc2;
                end
            end
        end
    end
endmodule

// File: tb/tb_lif_param_loader_multi.sv
// tb/tb_lif_param_loader_multi.sv - self-checking bench for lif_param_loader_multi
module tb_lif_param_loader_multi;
    localparam int N = 4;

    logic clk = 1'b0;
    logic reset, enable, serial_data_in, load_enable;
    logic [N*3-1:0] weight_a;
    logic [N*8-1:0] leak_rate_1, leak_rate_2, threshold;
    logic [N*4-1:0] leak_cycles_1, leak_cycles_2;
    logic           params_ready, csum_err, addr_err;
    logic [7:0]     frame_count;

    int n_pass = 0;
    int n_total = 0;
    bit chk_on = 1'b0;

    int m_wa[N], m_lr1[N], m_lr2[N], m_thr[N], m_lc1[N], m_lc2[N];
    int m_fc;
    bit m_ready, m_cerr, m_aerr;

    lif_param_loader_multi #(
        .N_CH(4), .W_WEIGHT(3), .W_RATE(8), .W_THR(8), .W_CYC(4),
        .DEF_WA(2), .DEF_LR1(2), .DEF_LR2(1), .DEF_THR(30), .DEF_LC1(2), .DEF_LC2(4)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .serial_data_in(serial_data_in), .load_enable(load_enable),
        .weight_a(weight_a), .leak_rate_1(leak_rate_1), .leak_rate_2(leak_rate_2),
        .threshold(threshold), .leak_cycles_1(leak_cycles_1), .leak_cycles_2(leak_cycles_2),
        .params_ready(params_ready), .csum_err(csum_err), .addr_err(addr_err),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic void model_reset();
        for (int k = 0; k < N; k++) begin
            m_wa[k] = 2; m_lr1[k] = 2; m_lr2[k] = 1; m_thr[k] = 30; m_lc1[k] = 2; m_lc2[k] = 4;
        end
        m_fc = 0; m_ready = 1; m_cerr = 0; m_aerr = 0;
    endfunction

    function automatic logic [63:0] mk(input logic [7:0] b0, b1, b2, b3, b4, b5, b6);
        logic [7:0] x;
        x = b0 ^ b1 ^ b2 ^ b3 ^ b4 ^ b5 ^ b6;
        return {b0, b1, b2, b3, b4, b5, b6, x};
    endfunction

    // Outcome of a complete frame, decided from its bytes alone
    function automatic void model_apply(input logic [63:0] f);
        logic [7:0] b[8];
        logic [7:0] x;
        x = 8'd0;
        for (int i = 0; i < 8; i++) begin
            b[i] = f[63-8*i -: 8];
            x ^= b[i];
        end
        m_ready = 1;
        if (x != 8'd0) m_cerr = 1;
        else if (!b[0][7] && int'(b[0][6:0]) >= N) m_aerr = 1;
        else begin
            for (int k = 0; k < N; k++) begin
                if (b[0][7] || int'(b[0][6:0]) == k) begin
                    m_wa[k] = b[1] % 8; m_lr1[k] = b[2]; m_lr2[k] = b[3];
                    m_thr[k] = b[4]; m_lc1[k] = b[5] % 16; m_lc2[k] = b[6] % 16;
                end
            end
            m_fc = (m_fc + 1) % 256;
        end
    endfunction

    always @(negedge clk) begin
        if (chk_on) begin
            logic [N*3-1:0] e_wa;
            logic [N*8-1:0] e_lr1, e_lr2, e_thr;
            logic [N*4-1:0] e_lc1, e_lc2;
            for (int k = 0; k < N; k++) begin
                e_wa[k*3 +: 3]  = 3'(m_wa[k]);
                e_lr1[k*8 +: 8] = 8'(m_lr1[k]);
                e_lr2[k*8 +: 8] = 8'(m_lr2[k]);
                e_thr[k*8 +: 8] = 8'(m_thr[k]);
                e_lc1[k*4 +: 4] = 4'(m_lc1[k]);
                e_lc2[k*4 +: 4] = 4'(m_lc2[k]);
            end
            chk("weight_a", 64'(weight_a), 64'(e_wa));
            chk("leak_rate_1", 64'(leak_rate_1), 64'(e_lr1));
            chk("leak_rate_2", 64'(leak_rate_2), 64'(e_lr2));
            chk("threshold", 64'(threshold), 64'(e_thr));
            chk("leak_cycles_1", 64'(leak_cycles_1), 64'(e_lc1));
            chk("leak_cycles_2", 64'(leak_cycles_2), 64'(e_lc2));
            chk("params_ready", 64'(params_ready), 64'(m_ready));
            chk("csum_err", 64'(csum_err), 64'(m_cerr));
            chk("addr_err", 64'(addr_err), 64'(m_aerr));
            chk("frame_count", 64'(frame_count), 64'(m_fc));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // nbits<64 aborts; gap_at freezes enable for 10 cycles; rst_at asserts reset before that bit
    task automatic send_frame(input logic [63:0] f, input int nbits, input int gap_at, input int rst_at);
        load_enable = 1'b1;
        tick();
        m_ready = 0; m_cerr = 0; m_aerr = 0;
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_at) begin
                reset = 1'b1;
                load_enable = 1'b0;
                #1;
                model_reset();
                chk("reset_immediate_thr", 64'(threshold), 64'h1e1e1e1e);
                chk("reset_immediate_ready", 64'(params_ready), 64'd1);
                tick();
                reset = 1'b0;
                tick();
                return;
            end
            if (i == gap_at) begin
                enable = 1'b0;
                repeat (10) tick();
                enable = 1'b1;
            end
            serial_data_in = f[63-i];
            tick();
        end
        if (nbits < 64) begin
            load_enable = 1'b0;
            tick();
            m_ready = 1;
            tick();
            return;
        end
        tick();
        model_apply(f);
        load_enable = 1'b0;
        tick();
        tick();
    endtask

    logic [63:0] fr_ch2;

    initial begin
        reset = 1'b1; enable = 1'b1; serial_data_in = 1'b0; load_enable = 1'b0;
        model_reset();
        chk_on = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        repeat (3) tick();
        chk("def_ch3_thr", 64'(threshold[3*8 +: 8]), 64'd30);
        chk("def_ch0_lc2", 64'(leak_cycles_2[0 +: 4]), 64'd4);
        chk("def_ch1_wa", 64'(weight_a[3 +: 3]), 64'd2);
        chk("def_fc", 64'(frame_count), 64'd0);

        fr_ch2 = mk(8'h02, 8'h05, 8'h10, 8'h03, 8'h40, 8'h07, 8'h09);
        send_frame(fr_ch2, 64, -1, -1);
        chk("ch2_wa", 64'(weight_a[6 +: 3]), 64'd5);
        chk("ch2_lr1", 64'(leak_rate_1[16 +: 8]), 64'd16);
        chk("ch2_lr2", 64'(leak_rate_2[16 +: 8]), 64'd3);
        chk("ch2_thr", 64'(threshold[16 +: 8]), 64'd64);
        chk("ch2_lc1", 64'(leak_cycles_1[8 +: 4]), 64'd7);
        chk("ch2_lc2", 64'(leak_cycles_2[8 +: 4]), 64'd9);
        chk("ch1_thr_kept", 64'(threshold[8 +: 8]), 64'd30);
        chk("fc_one", 64'(frame_count), 64'd1);

        send_frame(fr_ch2 ^ 64'h1, 64, -1, -1);
        chk("bad_csum_flag", 64'(csum_err), 64'd1);
        chk("bad_csum_fc", 64'(frame_count), 64'd1);

        send_frame(mk(8'h00, 8'hFD, 8'h21, 8'h22, 8'h23, 8'hF5, 8'hA6), 64, -1, -1);
        chk("csum_cleared", 64'(csum_err), 64'd0);
        chk("ch0_wa_masked", 64'(weight_a[0 +: 3]), 64'd5);
        chk("ch0_lc1_masked", 64'(leak_cycles_1[0 +: 4]), 64'd5);

        send_frame(mk(8'h80, 8'h05, 8'h10, 8'h03, 8'h50, 8'h07, 8'h09), 64, -1, -1);
        chk("bcast_thr", 64'(threshold), 64'h50505050);
        chk("fc_three", 64'(frame_count), 64'd3);

        send_frame(mk(8'h05, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01), 64, -1, -1);
        chk("addr_err_flag", 64'(addr_err), 64'd1);
        chk("addr_err_thr", 64'(threshold), 64'h50505050);

        send_frame(mk(8'h01, 8'h07, 8'h77, 8'h66, 8'h55, 8'h0C, 8'h0D), 30, -1, -1);
        chk("abort_ready", 64'(params_ready), 64'd1);
        chk("abort_flags", 64'({csum_err, addr_err}), 64'd0);
        chk("abort_ch1_thr", 64'(threshold[8 +: 8]), 64'd80);

        send_frame(mk(8'h03, 8'h06, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E), 64, 20, -1);
        chk("gap_ch3_thr", 64'(threshold[24 +: 8]), 64'd12);
        chk("gap_fc", 64'(frame_count), 64'd4);

        send_frame(mk(8'h01, 8'h07, 8'h77, 8'h66, 8'h55, 8'h0C, 8'h0D), 64, -1, 40);
        chk("rst_ch1_thr", 64'(threshold[8 +: 8]), 64'd30);
        chk("rst_fc", 64'(frame_count), 64'd0);

        for (int n = 0; n < 256; n++) begin
            send_frame(mk(8'h80, 8'(n), 8'(n + 1), 8'(n + 2), 8'(n * 3), 8'(n), 8'(n + 5)), 64, -1, -1);
            if (n == 254) chk("fc_255", 64'(frame_count), 64'd255);
        end
        chk("fc_wrap", 64'(frame_count), 64'd0);

        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
